// File: rtl/cell_update_queue.sv
// cell_update_queue: buffers the changed cells of each scanned frame for the LCD
// renderer. On overflow the rest of the frame is dropped and a full-frame
// resync is requested when the frame ends.
module cell_update_queue #(
    parameter int DEPTH  = 8,
    parameter int GRID_W = 16,
    parameter int GRID_H = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               x,
    input  logic [3:0]               y,
    input  logic [2:0]               obj_code,
    input  logic                     diff,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [3:0]               upd_x,
    output logic [3:0]               upd_y,
    output logic [2:0]               upd_code,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_done,
    output logic                     resync_req
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] ACCEPT = 1'b0;
    localparam logic [0:0] DROP   = 1'b1;
    localparam logic [4:0] GW = 5'(GRID_W);
    localparam logic [4:0] GH = 5'(GRID_H);

    // Entry layout: {x, y, obj_code}
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, nxt_rd;
    logic [CW-1:0] nxt_count;
    logic [0:0]    state;
    logic          accepted, last_cell, full, pop, push_req, push, overflow;
    logic [10:0]   in_entry, head;

    assign in_entry  = {x, y, obj_code};
    assign accepted  = in_valid && ({1'b0, x} < GW) && ({1'b0, y} < GH);
    assign last_cell = accepted && (x == 4'(GRID_W - 1)) && (y == 4'(GRID_H - 1));
    assign full      = (count == CW'(DEPTH));
    assign pop       = upd_valid && upd_ready;
    assign push_req  = accepted && diff && (state == ACCEPT);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push      = push_req && (!full || pop);
    assign overflow  = push_req && full && !pop;

    // Next head pointer/occupancy, so the registered outputs show the post-edge head.
    always_comb begin
        nxt_rd    = pop ? rd_ptr + 1'b1 : rd_ptr;
        nxt_count = count;
        if (push && !pop)      nxt_count = count + CW'(1);
        else if (pop && !push) nxt_count = count - CW'(1);
        // The entry being written becomes the head when nothing else is ahead of it.
        head = (push && (wr_ptr == nxt_rd)) ? in_entry : mem[nxt_rd];
    end

    // Storage array; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            upd_valid <= 1'b0;
            upd_x     <= '0;
            upd_y     <= '0;
            upd_code  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= nxt_rd;
            count     <= nxt_count;
            upd_valid <= (nxt_count != '0);
            if (nxt_count != '0) {upd_x, upd_y, upd_code} <= head;
        end
    end

    // Overflow FSM and frame-end pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCEPT;
            frame_done <= 1'b0;
            resync_req <= 1'b0;
        end else begin
            frame_done <= last_cell;
            resync_req <= last_cell && ((state == DROP) || overflow);
            if (last_cell)     state <= ACCEPT;
            else if (overflow) state <= DROP;
        end
    end
endmodule

// File: tb/tb_cell_update_queue.sv
// Directed bench for cell_update_queue with a reference model and an
// expected-entry scoreboard checked every cycle.
module tb_cell_update_queue;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, in_valid, diff, upd_ready;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic       upd_valid, frame_done, resync_req;
    logic [3:0] upd_x, upd_y;
    logic [2:0] upd_code;
    logic [3:0] count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [10:0] sb[$];
    int          mcount = 0;
    logic        mdrop = 1'b0;

    cell_update_queue #(.DEPTH(DEPTH), .GRID_W(16), .GRID_H(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
        .obj_code(obj_code), .diff(diff), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
        .upd_code(upd_code), .count(count), .frame_done(frame_done),
        .resync_req(resync_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, advance the model, check all outputs after the edge.
    task automatic step(input logic iv, input int cx, input int cy, input int code, input logic d);
        logic acc, popm, pr, pushm, ovf, lastc, efd, ers;
        in_valid = iv; x = 4'(cx); y = 4'(cy); obj_code = 3'(code); diff = d;
        acc   = iv && (cx < 16) && (cy < 12);
        popm  = (mcount != 0) && upd_ready;
        pr    = acc && d && !mdrop;
        pushm = pr && ((mcount < DEPTH) || popm);
        ovf   = pr && (mcount == DEPTH) && !popm;
        lastc = acc && (cx == 15) && (cy == 11);
        efd   = lastc;
        ers   = lastc && (mdrop || ovf);
        mdrop = lastc ? 1'b0 : (mdrop || ovf);
        if (popm) void'(sb.pop_front());
        if (pushm) sb.push_back({4'(cx), 4'(cy), 3'(code)});
        mcount = mcount + int'(pushm) - int'(popm);
        @(posedge clk); #1;
        chk("upd_valid", upd_valid, mcount != 0);
        chk("count", count, mcount);
        chk("frame_done", frame_done, efd);
        chk("resync_req", resync_req, ers);
        if (mcount != 0 && sb.size() != 0)
            chk("upd_entry", {upd_x, upd_y, upd_code}, sb[0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete(); mcount = 0; mdrop = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_valid", upd_valid, 0);
        chk("rst_entry", {upd_x, upd_y, upd_code}, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_rs", resync_req, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; obj_code = '0; diff = 1'b0;
        upd_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Idle after reset
        idle(100);

        // One raster frame with three changed cells
        for (int cy = 0; cy < 12; cy++)
            for (int cx = 0; cx < 16; cx++) begin
                logic dd;
                int   cc;
                dd = (cy == 4) && (cx == 4 || cx == 5 || cx == 7);
                cc = (cx == 4) ? 2 : (cx == 5) ? 1 : (cx == 7) ? 3 : 0;
                step(1'b1, cx, cy, cc, dd);
            end
        idle(5);
        chk("f1_drained", count, 0);

        // Stalled renderer: 8 fill, 9th overflows, frame finishes with resync
        upd_ready = 1'b0;
        for (int i = 0; i < 192; i++)
            step(1'b1, i % 16, i / 16, (i % 4) + 1, i < 9);
        chk("stall_count", count, 8);
        chk("stall_head", {upd_x, upd_y, upd_code}, {4'd0, 4'd0, 3'd1});
        upd_ready = 1'b1;
        idle(12);
        chk("stall_drained", count, 0);

        // Full FIFO with simultaneous push and pop
        upd_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, i, 7, 4, 1'b1);
        chk("full_count", count, 8);
        upd_ready = 1'b1;
        step(1'b1, 3, 2, 3, 1'b1);
        chk("pushpop_count", count, 8);
        idle(10);

        // Out-of-range and invalid cells
        step(1'b1, 0, 12, 1, 1'b1);
        step(1'b1, 15, 13, 2, 1'b1);
        step(1'b0, 15, 11, 3, 1'b1);
        step(1'b1, 15, 12, 3, 1'b1);
        idle(2);
        chk("oor_count", count, 0);

        // Reset mid-frame while in DROP with 5 entries held
        upd_ready = 1'b0;
        for (int i = 0; i < 9; i++) step(1'b1, i, 1, 2, 1'b1);
        upd_ready = 1'b1;
        idle(3);
        chk("drop_count5", count, 5);
        do_reset();
        for (int i = 0; i < 192; i++)
            step(1'b1, i % 16, i / 16, 5, (i == 20) || (i == 191));
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cell_update_queue.md
Name: cell_update_queue

Overview:
- Consumer end of the frame tracker's per-cell stream.
- Accepts one scanned cell per cycle (x, y, obj_code, diff). Only cells flagged as changed are buffered in a small FIFO.
- Changed cells are handed to the display renderer over a valid/ready handshake, so the LCD redraws only changed cells.
- Detects FIFO overflow. After an overflow it drops the rest of the frame and requests a full-frame resync at frame end.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- GRID_W, 16, grid columns; valid x range 0..GRID_W-1.
- GRID_H, 12, grid rows; valid y range 0..GRID_H-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  scanned cell present this cycle (tracker enable).
- x  in  4  cell column.
- y  in  4  cell row.
- obj_code  in  3  cell object: 000 empty, 001 head, 010 body, 011 apple, 100 border.
- diff  in  1  cell changed versus the previous frame.
- upd_valid  out  1  update entry available at head of FIFO.
- upd_ready  in  1  renderer accepts the head entry.
- upd_x  out  4  head entry column.
- upd_y  out  4  head entry row.
- upd_code  out  3  head entry object code.
- count  out  $clog2(DEPTH)+1  entries held.
- frame_done  out  1  one-cycle pulse after the last cell of a frame is accepted.
- resync_req  out  1  one-cycle pulse, coincident with frame_done, if the frame overflowed.

Behaviour:
- Reset values (rst high at posedge): FIFO empty, count=0, upd_valid=0, upd_x/upd_y/upd_code=0, frame_done=0, resync_req=0, FSM=ACCEPT. Reset mid-frame discards all stored entries and overflow state.
- Cell acceptance:
  - A cell is accepted when in_valid=1 and x<GRID_W and y<GRID_H.
  - Out-of-range cells are ignored entirely: no push, no frame-end detection.
- Push request: accepted cell with diff=1, state ACCEPT.
- Pop: upd_valid && upd_ready.
- FIFO:
  - Circular buffer with read/write pointers and a separate count; count updates on the same posedge as push/pop.
  - upd_* outputs are registered from the head entry, no fall-through: a push into an empty FIFO gives upd_valid=1 on the next cycle (latency 1).
  - Entries emerge in scan order.
  - Empty: pop ignored, upd_valid=0.
  - Full plus push plus pop in the same cycle: both happen, count stays DEPTH, no overflow.
  - Empty plus push plus pop: pop has no effect, the push lands.
  - upd_* hold stable while upd_valid=1 and upd_ready=0.
- FSM:
  - ACCEPT: normal operation. Push request while count==DEPTH and no pop the same cycle: the entry is dropped and the state goes to DROP.
  - DROP: all push requests are dropped. Pops continue, so the renderer drains the entries already stored.
- Frame end:
  - Triggered by an accepted cell with x==GRID_W-1 and y==GRID_H-1.
  - Next cycle: frame_done=1 for one cycle.
  - If the state was DROP (including a DROP entered on this same cell): resync_req=1 that cycle and the state returns to ACCEPT.
  - If the frame-end cell itself pushes successfully: the push and frame_done are independent.
- Width rules: count ranges 0..DEPTH; pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset then idle 100 cycles, upd_ready=1 -> upd_valid=0, count=0, frame_done=0, resync_req=0 throughout.
- One 192-cell frame in raster order, diff=1 only at (4,4)=010, (5,4)=001, (7,4)=011; upd_ready=1 -> renderer receives exactly those three, in order (4,4,010), (5,4,001), (7,4,011), each 1 cycle after its push; frame_done pulses 1 cycle after (15,11); no resync_req.
- upd_ready=0, DEPTH=8, push 8 changed cells -> count=8, upd_* frozen on the first entry; 9th changed cell -> dropped, state DROP; finish frame -> frame_done and resync_req both pulse once; raise upd_ready -> exactly 8 entries drain, in order.
- Count=8, same cycle push (3,2,011) and pop with upd_ready=1 -> no overflow, count stays 8, (3,2,011) is the last entry out.
- in_valid=1 with y=12 or x=15/y=13 and diff=1 -> no push, no frame_done; in_valid=0 with x=15, y=11 -> no frame_done.
- Assert rst for 1 cycle while count=5 in DROP -> next cycle count=0, upd_valid=0; the following frame pushes normally with no resync_req.
